// File: rtl/audio_pkg.sv
// Shared types, FSM encodings and helpers for the audio frame mixer.
package audio_pkg;

    typedef enum logic [1:0] {
        ROUTE_MONO  = 2'b00,
        ROUTE_LEFT  = 2'b01,
        ROUTE_RIGHT = 2'b10,
        ROUTE_MUTE  = 2'b11
    } route_t;

    // FSM state encoding, kept as plain constants for compatibility with older blocks.
    typedef logic [2:0] state_t;
    localparam state_t StIdle = 3'd0;
    localparam state_t StScan = 3'd1;
    localparam state_t StAddr = 3'd2;
    localparam state_t StData = 3'd3;
    localparam state_t StMac  = 3'd4;
    localparam state_t StSat  = 3'd5;
    localparam state_t StOut  = 3'd6;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // Clamp a signed value into the signed range of a width-bit result.
    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] acc,
                                                     input int unsigned width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (acc > hi) begin
            return hi;
        end else if (acc < lo) begin
            return lo;
        end
        return acc;
    endfunction

endpackage

// File: rtl/audio_frame_mixer_gain_mac.sv
// Per-sample gain and routing into the stereo accumulators.
module audio_gain_mac
    import audio_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned VOL_W    = 8,
    parameter int unsigned ACC_W    = 21
) (
    input  logic                     clk,
    input  logic                     aresetn,
    input  logic                     clr_i,
    input  logic                     en_i,
    input  logic [SAMPLE_W-1:0]      sample_i,
    input  logic [VOL_W-1:0]         volume_i,
    input  route_t                   route_i,
    output logic signed [ACC_W-1:0]  prod_o,
    output logic signed [ACC_W-1:0]  acc_l_o,
    output logic signed [ACC_W-1:0]  acc_r_o
);

    localparam int unsigned PROD_W = SAMPLE_W + VOL_W + 1;

    logic signed [SAMPLE_W-1:0] sample_s;
    logic signed [VOL_W:0]      vol_s;
    logic signed [PROD_W-1:0]   prod_full;
    logic signed [PROD_W-1:0]   prod_sh;
    logic signed [ACC_W-1:0]    acc_l_q;
    logic signed [ACC_W-1:0]    acc_r_q;

    // Volume is unsigned, so it gets a zero sign bit before the signed multiply.
    assign sample_s  = $signed(sample_i);
    assign vol_s     = $signed({1'b0, volume_i});
    assign prod_full = PROD_W'(sample_s) * PROD_W'(vol_s);
    assign prod_sh   = prod_full >>> (VOL_W - 1);
    assign prod_o    = ACC_W'(prod_sh);

    // Accumulate the scaled sample into the sides selected by the route.
    always_ff @(posedge clk) begin
        if (!aresetn || clr_i) begin
            acc_l_q <= '0;
            acc_r_q <= '0;
        end else if (en_i) begin
            if (route_i == ROUTE_MONO || route_i == ROUTE_LEFT) begin
                acc_l_q <= acc_l_q + prod_o;
            end
            if (route_i == ROUTE_MONO || route_i == ROUTE_RIGHT) begin
                acc_r_q <= acc_r_q + prod_o;
            end
        end
    end

    assign acc_l_o = acc_l_q;
    assign acc_r_o = acc_r_q;

endmodule

// File: rtl/audio_frame_mixer.sv
// Frame-tick driven sample fetcher and stereo mixer with an AXI-Lite read master.
module audio_frame_mixer
    import audio_pkg::*;
#(
    parameter int unsigned NUM_CH     = 8,
    parameter int unsigned SAMPLE_W   = 16,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned SWAP_BYTES = 1,
    parameter int unsigned VOL_W      = 8
) (
    input  logic                       clk,
    input  logic                       aresetn,
    input  logic                       frame_tick,
    input  logic [NUM_CH-1:0]          ch_active,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
    input  logic [NUM_CH*VOL_W-1:0]    ch_volume,
    input  logic [NUM_CH*2-1:0]        ch_route,
    output logic [NUM_CH-1:0]          ch_ack,
    output logic [ADDR_W-1:0]          m_axil_araddr,
    output logic [2:0]                 m_axil_arprot,
    output logic                       m_axil_arvalid,
    input  logic                       m_axil_arready,
    input  logic [SAMPLE_W-1:0]        m_axil_rdata,
    input  logic [1:0]                 m_axil_rresp,
    input  logic                       m_axil_rvalid,
    output logic                       m_axil_rready,
    output logic [SAMPLE_W-1:0]        out_left,
    output logic [SAMPLE_W-1:0]        out_right,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       overrun,
    output logic                       resp_err
);

    localparam int unsigned IDX_W = $clog2(NUM_CH + 1);
    localparam int unsigned ACC_W = SAMPLE_W + 2 + $clog2(NUM_CH);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [ADDR_W-1:0]      araddr_q, araddr_d;
    logic                   arvalid_q, arvalid_d;
    logic                   rready_q, rready_d;
    logic [SAMPLE_W-1:0]    sample_q, sample_d;
    logic [SAMPLE_W-1:0]    out_left_q, out_left_d;
    logic [SAMPLE_W-1:0]    out_right_q, out_right_d;
    logic                   out_valid_q, out_valid_d;
    logic                   overrun_q, overrun_d;
    logic                   resp_err_q, resp_err_d;

    logic                   act_sel;
    logic [ADDR_W-1:0]      addr_sel;
    logic [VOL_W-1:0]       vol_sel;
    route_t                 route_sel;
    logic [SAMPLE_W-1:0]    rdata_sw;
    logic                   acc_clr;
    logic                   acc_en;
    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] acc_l;
    logic signed [ACC_W-1:0] acc_r;

    // Select the configuration of the channel currently being visited.
    always_comb begin
        act_sel   = 1'b0;
        addr_sel  = '0;
        vol_sel   = '0;
        route_sel = ROUTE_MUTE;
        for (int i = 0; i < NUM_CH; i++) begin
            if (idx_q == IDX_W'(i)) begin
                act_sel   = ch_active[i];
                addr_sel  = ch_addr[i*ADDR_W +: ADDR_W];
                vol_sel   = ch_volume[i*VOL_W +: VOL_W];
                route_sel = route_t'(ch_route[2*i +: 2]);
            end
        end
    end

    // Samples are stored big-endian in little-endian memory, so reverse bytes when enabled.
    always_comb begin
        rdata_sw = m_axil_rdata;
        if (SWAP_BYTES != 0) begin
            for (int b = 0; b < SAMPLE_W / 8; b++) begin
                rdata_sw[8*b +: 8] = m_axil_rdata[SAMPLE_W-8-8*b +: 8];
            end
        end
    end

    // Frame sequencing: scan channels, fetch, mix, saturate and hand off.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        sample_d    = sample_q;
        out_left_d  = out_left_q;
        out_right_d = out_right_q;
        out_valid_d = out_valid_q;
        overrun_d   = frame_tick && (state_q != StIdle);
        resp_err_d  = 1'b0;
        acc_clr     = 1'b0;
        acc_en      = 1'b0;
        case (state_q)
            StIdle: begin
                if (frame_tick) begin
                    acc_clr = 1'b1;
                    idx_d   = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (idx_q == IDX_W'(NUM_CH)) begin
                    state_d = StSat;
                end else if (!act_sel || route_sel == ROUTE_MUTE) begin
                    idx_d = idx_q + IDX_W'(1);
                end else begin
                    araddr_d  = addr_sel;
                    arvalid_d = 1'b1;
                    state_d   = StAddr;
                end
            end
            StAddr: begin
                if (m_axil_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = StData;
                end
            end
            StData: begin
                if (m_axil_rvalid && rready_q) begin
                    rready_d = 1'b0;
                    if (m_axil_rresp == AXI_RESP_OKAY) begin
                        sample_d = rdata_sw;
                    end else begin
                        // A failed read still consumes the channel, contributing silence.
                        sample_d   = '0;
                        resp_err_d = 1'b1;
                    end
                    state_d = StMac;
                end
            end
            StMac: begin
                acc_en  = 1'b1;
                idx_d   = idx_q + IDX_W'(1);
                state_d = StScan;
            end
            StSat: begin
                out_left_d  = SAMPLE_W'(sat_clamp(64'(acc_l), SAMPLE_W));
                out_right_d = SAMPLE_W'(sat_clamp(64'(acc_r), SAMPLE_W));
                out_valid_d = 1'b1;
                state_d     = StOut;
            end
            StOut: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            sample_q    <= '0;
            out_left_q  <= '0;
            out_right_q <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            sample_q    <= sample_d;
            out_left_q  <= out_left_d;
            out_right_q <= out_right_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            resp_err_q  <= resp_err_d;
        end
    end

    // The channel is acknowledged during its MAC cycle.
    always_comb begin
        ch_ack = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_ack[i] = (state_q == StMac) && (idx_q == IDX_W'(i));
        end
    end

    audio_gain_mac #(
        .SAMPLE_W (SAMPLE_W),
        .VOL_W    (VOL_W),
        .ACC_W    (ACC_W)
    ) u_gain_mac (
        .clk      (clk),
        .aresetn  (aresetn),
        .clr_i    (acc_clr),
        .en_i     (acc_en),
        .sample_i (sample_q),
        .volume_i (vol_sel),
        .route_i  (route_sel),
        .prod_o   (prod),
        .acc_l_o  (acc_l),
        .acc_r_o  (acc_r)
    );

    assign m_axil_araddr  = araddr_q;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_rready  = rready_q;
    assign out_left       = out_left_q;
    assign out_right      = out_right_q;
    assign out_valid      = out_valid_q;
    assign busy           = (state_q != StIdle);
    assign overrun        = overrun_q;
    assign resp_err       = resp_err_q;

endmodule

// File: tb/tb_audio_frame_mixer.sv
// Scoreboard bench for audio_frame_mixer with a delay-configurable AXI-Lite slave.
module tb_audio_frame_mixer;

    localparam int NUM_CH = 8;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
    } frame_t;

    logic               clk = 1'b0;
    logic               aresetn = 1'b0;
    logic               frame_tick = 1'b0;
    logic [7:0]         ch_active = '0;
    logic [255:0]       ch_addr = '0;
    logic [63:0]        ch_volume = '0;
    logic [15:0]        ch_route = '0;
    logic [7:0]         ch_ack;
    logic [31:0]        araddr;
    logic [2:0]         arprot;
    logic               arvalid;
    logic               arready = 1'b0;
    logic [15:0]        rdata = '0;
    logic [1:0]         rresp = '0;
    logic               rvalid = 1'b0;
    logic               rready;
    logic [15:0]        out_left, out_right;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic               busy, overrun, resp_err;

    int tests = 0;
    int fails = 0;

    bit          cfg_act[NUM_CH];
    logic [7:0]  cfg_vol[NUM_CH];
    logic [1:0]  cfg_route[NUM_CH];
    logic [15:0] mem[logic [31:0]];
    bit          err_addr[logic [31:0]];
    frame_t      exp_q[$];

    int          ar_delay = 0;
    int          r_delay = 0;
    int          ar_beats = 0;
    int          ar_unstable = 0;
    logic [31:0] ar_log[$];
    int          ack_cnt[NUM_CH];
    int          ov_cnt = 0;
    int          re_cnt = 0;

    audio_frame_mixer #(
        .NUM_CH(8), .SAMPLE_W(16), .ADDR_W(32), .SWAP_BYTES(1), .VOL_W(8)
    ) dut (
        .clk(clk), .aresetn(aresetn), .frame_tick(frame_tick),
        .ch_active(ch_active), .ch_addr(ch_addr), .ch_volume(ch_volume), .ch_route(ch_route),
        .ch_ack(ch_ack),
        .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid),
        .m_axil_arready(arready), .m_axil_rdata(rdata), .m_axil_rresp(rresp),
        .m_axil_rvalid(rvalid), .m_axil_rready(rready),
        .out_left(out_left), .out_right(out_right), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .overrun(overrun), .resp_err(resp_err)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] chaddr(int i);
        return 32'h1000 + 32'(i) * 32'h10;
    endfunction

    function automatic logic [15:0] swap16(logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

    function automatic logic [15:0] clamp16(longint v);
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    function automatic logic [7:0] ack_pattern();
        logic [7:0] p = '0;
        for (int i = 0; i < NUM_CH; i++) p[i] = (ack_cnt[i] != 0);
        return p;
    endfunction

    function automatic int ack_total();
        int t = 0;
        for (int i = 0; i < NUM_CH; i++) t += ack_cnt[i];
        return t;
    endfunction

    // AXI-Lite read slave: programmable AR and R delays, watches AR stability while stalling.
    initial begin
        logic [31:0] a;
        forever begin
            @(posedge clk); #1;
            if (arvalid) begin
                a = araddr;
                for (int k = 0; k < ar_delay; k++) begin
                    @(posedge clk); #1;
                    if (!arvalid || araddr !== a) ar_unstable++;
                end
                arready = 1'b1;
                @(posedge clk); #1;
                arready = 1'b0;
                ar_beats++;
                ar_log.push_back(a);
                for (int k = 0; k < r_delay; k++) begin
                    @(posedge clk); #1;
                end
                rvalid = 1'b1;
                rdata  = mem.exists(a) ? mem[a] : 16'hDEAD;
                rresp  = err_addr.exists(a) ? 2'b10 : 2'b00;
                @(posedge clk); #1;
                rvalid = 1'b0;
                rresp  = 2'b00;
            end
        end
    end

    // Pulse monitors.
    always @(negedge clk) begin
        for (int i = 0; i < NUM_CH; i++) if (ch_ack[i]) ack_cnt[i]++;
        if (overrun) ov_cnt++;
        if (resp_err) re_cnt++;
    end

    task automatic clear_cfg();
        for (int i = 0; i < NUM_CH; i++) begin
            cfg_act[i] = 1'b0;
            cfg_vol[i] = 8'd128;
            cfg_route[i] = 2'b00;
        end
        mem.delete();
        err_addr.delete();
    endtask

    task automatic apply_cfg();
        for (int i = 0; i < NUM_CH; i++) begin
            ch_active[i] = cfg_act[i];
            ch_addr[i*32 +: 32] = chaddr(i);
            ch_volume[i*8 +: 8] = cfg_vol[i];
            ch_route[2*i +: 2] = cfg_route[i];
        end
    endtask

    task automatic clear_counters();
        for (int i = 0; i < NUM_CH; i++) ack_cnt[i] = 0;
        ov_cnt = 0;
        re_cnt = 0;
        ar_beats = 0;
        ar_unstable = 0;
        ar_log.delete();
    endtask

    task automatic set_ch(int i, logic [15:0] sample, logic [7:0] vol, logic [1:0] route);
        cfg_act[i] = 1'b1;
        cfg_vol[i] = vol;
        cfg_route[i] = route;
        mem[chaddr(i)] = swap16(sample);
    endtask

    // Reference mix of the current configuration, pushed to the scoreboard.
    task automatic model_push();
        longint l = 0, r = 0, s, p;
        logic [31:0] a;
        logic [15:0] raw;
        frame_t f;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_act[i] && cfg_route[i] != 2'b11) begin
                a = chaddr(i);
                raw = mem.exists(a) ? mem[a] : 16'hDEAD;
                if (err_addr.exists(a)) s = 0;
                else s = longint'($signed(swap16(raw)));
                p = (s * longint'(cfg_vol[i])) >>> 7;
                if (cfg_route[i] == 2'b00 || cfg_route[i] == 2'b01) l += p;
                if (cfg_route[i] == 2'b00 || cfg_route[i] == 2'b10) r += p;
            end
        end
        f.l = clamp16(l);
        f.r = clamp16(r);
        exp_q.push_back(f);
    endtask

    task automatic tick();
        @(posedge clk); #1;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
    endtask

    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({arvalid, rready, out_valid, busy, overrun, resp_err} !== 6'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {arvalid, rready, out_valid, busy, overrun, resp_err});
        end
        tests++;
        if ({ch_ack, out_left, out_right, araddr, arprot} !== '0) begin
            fails++;
            $display("FAIL reset_data: got ack=%h l=%h r=%h addr=%h prot=%h want all 0",
                     ch_ack, out_left, out_right, araddr, arprot);
        end
        aresetn = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_single();
        bit ok;
        frame_t e;
        clear_cfg(); clear_counters();
        set_ch(0, 16'h1234, 8'd128, 2'b00);
        apply_cfg(); model_push();
        tick(); wait_out(ok);
        e = exp_q.pop_front();
        tests++;
        if (!ok || out_left !== e.l || out_right !== e.r) begin
            fails++;
            $display("FAIL single_out: got %h/%h want %h/%h", out_left, out_right, e.l, e.r);
        end
        tests++;
        if (ar_log.size() != 1 || ar_log[0] !== chaddr(0)) begin
            fails++;
            $display("FAIL single_araddr: got %0d beats first %h want 1 beat %h",
                     ar_log.size(), (ar_log.size() > 0) ? ar_log[0] : 32'h0, chaddr(0));
        end
        tests++;
        if (ack_pattern() !== 8'h01 || ack_total() != 1) begin
            fails++;
            $display("FAIL single_ack: got %h (%0d) want 01 (1)", ack_pattern(), ack_total());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_saturate();
        bit ok;
        frame_t e;
        clear_cfg(); clear_counters();
        set_ch(0, 16'h7000, 8'd128, 2'b01);
        set_ch(1, 16'h7000, 8'd128, 2'b01);
        set_ch(2, 16'h8000, 8'd255, 2'b10);
        apply_cfg(); model_push();
        tick(); wait_out(ok);
        e = exp_q.pop_front();
        tests++;
        if (!ok || out_left !== e.l || out_right !== e.r) begin
            fails++;
            $display("FAIL saturate_out: got %h/%h want %h/%h", out_left, out_right, e.l, e.r);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sparse();
        bit ok;
        frame_t e;
        clear_cfg(); clear_counters();
        set_ch(3, 16'h0100, 8'd64, 2'b00);
        apply_cfg(); model_push();
        tick(); wait_out(ok);
        e = exp_q.pop_front();
        tests++;
        if (!ok || out_left !== e.l || out_right !== e.r) begin
            fails++;
            $display("FAIL sparse_out: got %h/%h want %h/%h", out_left, out_right, e.l, e.r);
        end
        tests++;
        if (ar_beats != 1 || ack_pattern() !== 8'h08) begin
            fails++;
            $display("FAIL sparse_beats: got %0d beats ack %h want 1 beat ack 08",
                     ar_beats, ack_pattern());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_empty();
        bit ok;
        frame_t e;
        clear_cfg(); clear_counters();
        set_ch(4, 16'h4000, 8'd200, 2'b11);
        apply_cfg(); model_push();
        tick(); wait_out(ok);
        e = exp_q.pop_front();
        tests++;
        if (!ok || out_left !== e.l || out_right !== e.r) begin
            fails++;
            $display("FAIL empty_out: got %h/%h want %h/%h", out_left, out_right, e.l, e.r);
        end
        tests++;
        if (ar_beats != 0 || ack_total() != 0) begin
            fails++;
            $display("FAIL empty_beats: got %0d beats %0d acks want 0/0", ar_beats, ack_total());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_delays();
        bit ok;
        frame_t e;
        clear_cfg(); clear_counters();
        ar_delay = 5; r_delay = 3;
        set_ch(0, 16'h0400, 8'd100, 2'b00);
        set_ch(2, 16'hF000, 8'd128, 2'b01);
        set_ch(5, 16'h2222, 8'd255, 2'b10);
        apply_cfg(); model_push();
        tick(); wait_out(ok);
        e = exp_q.pop_front();
        tests++;
        if (!ok || out_left !== e.l || out_right !== e.r) begin
            fails++;
            $display("FAIL delays_out: got %h/%h want %h/%h", out_left, out_right, e.l, e.r);
        end
        tests++;
        if (ar_unstable != 0 || ar_beats != 3) begin
            fails++;
            $display("FAIL delays_ar: got unstable=%0d beats=%0d want 0/3", ar_unstable, ar_beats);
        end
        tests++;
        if (ack_pattern() !== 8'h25 || ack_total() != 3) begin
            fails++;
            $display("FAIL delays_ack: got %h (%0d) want 25 (3)", ack_pattern(), ack_total());
        end
        ar_delay = 0; r_delay = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_overrun();
        bit ok;
        frame_t e;
        clear_cfg(); clear_counters();
        for (int i = 0; i < 4; i++) set_ch(i, 16'h0100 * 16'(i + 1), 8'd128, 2'b00);
        apply_cfg(); model_push();
        tick();
        repeat (3) @(posedge clk);
        #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        wait_out(ok);
        e = exp_q.pop_front();
        tests++;
        if (!ok || out_left !== e.l || out_right !== e.r) begin
            fails++;
            $display("FAIL overrun_out: got %h/%h want %h/%h", out_left, out_right, e.l, e.r);
        end
        tests++;
        if (ov_cnt != 1 || ar_beats != 4) begin
            fails++;
            $display("FAIL overrun_pulse: got %0d pulses %0d beats want 1/4", ov_cnt, ar_beats);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_resp_err();
        bit ok;
        frame_t e;
        clear_cfg(); clear_counters();
        set_ch(0, 16'h0100, 8'd128, 2'b00);
        set_ch(1, 16'h4000, 8'd128, 2'b00);
        set_ch(2, 16'h0200, 8'd128, 2'b01);
        err_addr[chaddr(1)] = 1'b1;
        apply_cfg(); model_push();
        tick(); wait_out(ok);
        e = exp_q.pop_front();
        tests++;
        if (!ok || out_left !== e.l || out_right !== e.r) begin
            fails++;
            $display("FAIL resp_err_out: got %h/%h want %h/%h", out_left, out_right, e.l, e.r);
        end
        tests++;
        if (re_cnt != 1 || ack_cnt[1] != 1 || ack_pattern() !== 8'h07) begin
            fails++;
            $display("FAIL resp_err_pulse: got err=%0d ack1=%0d acks=%h want 1/1/07",
                     re_cnt, ack_cnt[1], ack_pattern());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        bit ok;
        int bad = 0;
        frame_t e;
        logic [15:0] hl, hr;
        clear_cfg(); clear_counters();
        set_ch(1, 16'h1111, 8'd200, 2'b00);
        set_ch(6, 16'hFF00, 8'd50, 2'b10);
        apply_cfg(); model_push();
        out_ready = 1'b0;
        tick(); wait_out(ok);
        e = exp_q.pop_front();
        hl = out_left; hr = out_right;
        tests++;
        if (!ok || hl !== e.l || hr !== e.r) begin
            fails++;
            $display("FAIL bp_out: got %h/%h want %h/%h", hl, hr, e.l, e.r);
        end
        repeat (10) begin
            @(negedge clk);
            if (!out_valid || out_left !== hl || out_right !== hr) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL bp_hold: got %0d unstable cycles want 0", bad);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b0 || out_left !== hl || out_right !== hr) begin
            fails++;
            $display("FAIL bp_release: got valid=%b %h/%h want 0 %h/%h",
                     out_valid, out_left, out_right, hl, hr);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen = 1'b0;
        frame_t e;
        clear_cfg(); clear_counters();
        set_ch(0, 16'h5555, 8'd128, 2'b00);
        apply_cfg();
        r_delay = 8;
        tick();
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rready) begin
                seen = 1'b1;
                break;
            end
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL rst_mid_reach: got no DATA state want rready=1");
        end
        aresetn = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({arvalid, rready, out_valid, busy, overrun, resp_err, ch_ack} !== '0 ||
            {out_left, out_right, araddr} !== '0) begin
            fails++;
            $display("FAIL rst_mid_outs: got av=%b rr=%b ov=%b bz=%b ack=%h l=%h r=%h a=%h want 0",
                     arvalid, rready, out_valid, busy, ch_ack, out_left, out_right, araddr);
        end
        aresetn = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        tests++;
        if (ack_total() != 0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_noack: got %0d acks valid=%b want 0/0", ack_total(), out_valid);
        end
        r_delay = 0;
        clear_counters();
        model_push();
        tick(); wait_out(ok);
        e = exp_q.pop_front();
        tests++;
        if (!ok || out_left !== e.l || out_right !== e.r || ar_beats != 1) begin
            fails++;
            $display("FAIL rst_mid_clean: got %h/%h beats %0d want %h/%h beats 1",
                     out_left, out_right, ar_beats, e.l, e.r);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        clear_cfg();
        clear_counters();
        apply_cfg();
        test_reset();
        test_single();
        test_saturate();
        test_sparse();
        test_empty();
        test_delays();
        test_overrun();
        test_resp_err();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
